// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory bridge.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, access legality, and load lane select with
// sign/zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_steer,
  output logic        misalign,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] bus_rdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte_s;
  logic [15:0] lane_half_s;

  // Request decode: enables, replicated store data, and fault detection.
  always_comb begin
    be          = 4'b0000;
    wdata_steer = 32'h0000_0000;
    misalign    = 1'b0;
    case (funct3)
      F3_B: begin
        be          = 4'b0001 << addr_lo;
        wdata_steer = {4{wdata[7:0]}};
      end
      F3_H: begin
        be          = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_steer = {2{wdata[15:0]}};
        misalign    = addr_lo[0];
      end
      F3_W: begin
        be          = 4'b1111;
        wdata_steer = wdata;
        misalign    = |addr_lo;
      end
      F3_BU: begin
        // Unsigned sizes exist only for loads.
        be       = 4'b0001 << addr_lo;
        misalign = we;
      end
      F3_HU: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = we | addr_lo[0];
      end
      default: begin
        misalign = 1'b1;
      end
    endcase
  end

  // Pick the addressed byte and halfword out of the returned word.
  always_comb begin
    case (ld_addr_lo)
      2'd0:    lane_byte_s = bus_rdata[7:0];
      2'd1:    lane_byte_s = bus_rdata[15:8];
      2'd2:    lane_byte_s = bus_rdata[23:16];
      2'd3:    lane_byte_s = bus_rdata[31:24];
      default: lane_byte_s = 8'h00;
    endcase
    lane_half_s = ld_addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  end

  // Extend the selected lane to 32 bits.
  always_comb begin
    case (ld_funct3)
      F3_B:    load_data = {{24{lane_byte_s[7]}}, lane_byte_s};
      F3_H:    load_data = {{16{lane_half_s[15]}}, lane_half_s};
      F3_W:    load_data = bus_rdata;
      F3_BU:   load_data = {24'h00_0000, lane_byte_s};
      F3_HU:   load_data = {16'h0000, lane_half_s};
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Runs the datapath's load/store as a req/gnt/rvalid bus transaction and
// stalls the core until the result is available in DONE.
module lsu_mem_bridge
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misalign,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       ld_funct3_r;
  logic [1:0]       ld_addr_lo_r;

  logic             req_s;
  logic [3:0]       be_s;
  logic [31:0]      wdata_s;
  logic             misalign_s;
  logic [31:0]      load_s;

  assign req_s = rd_en | wr_en;
  assign stall = ((state_r == IDLE) & req_s) | (state_r == REQ) | (state_r == WAIT);

  lsu_align u_align (
    .funct3      (funct3),
    .addr_lo     (addr[1:0]),
    .we          (wr_en),
    .wdata       (wdata),
    .be          (be_s),
    .wdata_steer (wdata_s),
    .misalign    (misalign_s),
    .ld_funct3   (ld_funct3_r),
    .ld_addr_lo  (ld_addr_lo_r),
    .bus_rdata   (bus_rdata),
    .load_data   (load_s)
  );

  // Transaction FSM with timeout counter and registered bus/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      ld_funct3_r  <= 3'b000;
      ld_addr_lo_r <= 2'b00;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_be       <= 4'b0000;
      bus_addr     <= '0;
      bus_wdata    <= 32'h0000_0000;
      rdata        <= 32'h0000_0000;
      misalign     <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s && misalign_s) begin
            misalign <= 1'b1;
            rdata    <= 32'h0000_0000;
            state_r  <= DONE;
          end else if (req_s) begin
            bus_addr     <= {addr[ADDR_W-1:2], 2'b00};
            bus_we       <= wr_en;
            bus_be       <= be_s;
            bus_wdata    <= wdata_s;
            ld_funct3_r  <= funct3;
            ld_addr_lo_r <= addr[1:0];
            bus_req      <= 1'b1;
            cnt_r        <= '0;
            state_r      <= REQ;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (bus_gnt) begin
            bus_req <= 1'b0;
            cnt_r   <= cnt_r + CNT_ONE;
            state_r <= WAIT;
          end else if (cnt_r >= CNT_LAST) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            rdata   <= 32'h0000_0000;
            cnt_r   <= '0;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        WAIT: begin
          // A grant on the final REQ cycle lands here past CNT_LAST, hence >=.
          if (bus_rvalid) begin
            rdata   <= bus_we ? 32'h0000_0000 : load_s;
            cnt_r   <= '0;
            state_r <= DONE;
          end else if (cnt_r >= CNT_LAST) begin
            bus_err <= 1'b1;
            rdata   <= 32'h0000_0000;
            cnt_r   <= '0;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DONE: begin
          rdata    <= 32'h0000_0000;
          misalign <= 1'b0;
          bus_err  <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          bus_req <= 1'b0;
          cnt_r   <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Randomized and directed bench for lsu_mem_bridge with an arithmetic reference model.
module tb_lsu_mem_bridge;
  import lsu_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        stall, misalign, bus_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
    int          reqs;
    int          stalls;
    logic [31:0] rdata;
    logic        mis;
    logic        err;
    logic        cleared;
    logic        finished;
  } obs_t;

  always #5 clk = ~clk;

  lsu_mem_bridge #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  function automatic logic model_fault(logic wr, logic [2:0] f3, logic [31:0] a);
    logic legal;
    int   sz;
    legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
    sz = 1 << f3[1:0];
    return (a % sz) != 0;
  endfunction

  function automatic logic [3:0] model_be(logic [2:0] f3, logic [31:0] a);
    int sz;
    sz = 1 << f3[1:0];
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] wd);
    if (f3[1:0] == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    else if (f3[1:0] == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    else return wd;
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rw);
    logic [31:0] v;
    v = rw >> (8 * (a % 4));
    if (f3[1:0] == 2'd0) begin
      v = v & 32'hFF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (f3[1:0] == 2'd1) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rw;
    end
    return v;
  endfunction

  // Acts as core and bus: issues one access, grants after gd request cycles,
  // responds rdly cycles into WAIT, and records what the DUT did.
  task automatic do_txn(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                        input int gd, input int rdly, input logic spur, output obs_t o);
    int   wait_cnt;
    logic granted;
    o.addr = '0; o.be = '0; o.wd = '0; o.we = 1'b0; o.reqs = 0; o.stalls = 0;
    o.rdata = '0; o.mis = 1'b0; o.err = 1'b0; o.cleared = 1'b0; o.finished = 1'b0;
    wait_cnt = 0;
    granted  = 1'b0;
    @(negedge clk);
    rd_en = rd; wr_en = wr; funct3 = f3; addr = a; wdata = wd; bus_rdata = ~rw;
    for (int cyc = 0; cyc < 60 && !o.finished; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      if (stall) o.stalls++;
      if (bus_req) begin
        if (o.reqs == 0) begin
          o.addr = bus_addr; o.be = bus_be; o.wd = bus_wdata; o.we = bus_we;
        end
        if (o.reqs == gd) begin
          bus_gnt = 1'b1; granted = 1'b1; bus_rvalid = spur;
        end
        o.reqs++;
      end else if (stall && granted) begin
        if (wait_cnt == rdly) begin
          bus_rvalid = 1'b1; bus_rdata = rw;
        end
        wait_cnt++;
      end else if (!stall) begin
        o.rdata = rdata; o.mis = misalign; o.err = bus_err; o.finished = 1'b1;
        rd_en = 1'b0; wr_en = 1'b0;
      end
    end
    rd_en = 1'b0; wr_en = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    #1;
    o.cleared = (rdata == 32'h0) && !misalign && !bus_err && !stall && !bus_req;
  endtask

  task automatic test_reset;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata, rdata, misalign, bus_err, stall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b we=%b be=%b addr=%h wd=%h rdata=%h mis=%b err=%b stall=%b want all 0",
               bus_req, bus_we, bus_be, bus_addr, bus_wdata, rdata, misalign, bus_err, stall);
    end
    rd_en = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL reset_idle_stall got %b want 1", stall);
    end
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_word;
    obs_t o;
    do_txn(1'b0, 1'b1, F3_W, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0, o);
    checks++;
    if ({o.addr, o.be, o.wd, o.we} !== {32'h100, 4'b1111, 32'hDEAD_BEEF, 1'b1}) begin
      errors++;
      $display("FAIL sw_bus got addr=%h be=%b wd=%h we=%b want 00000100 1111 deadbeef 1", o.addr, o.be, o.wd, o.we);
    end
    checks++;
    if (o.stalls !== 3 || o.reqs !== 1) begin
      errors++; $display("FAIL sw_latency got stall=%0d req=%0d want 3 1", o.stalls, o.reqs);
    end
    checks++;
    if ({o.finished, o.rdata, o.mis, o.err, o.cleared} !== {1'b1, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sw_done got fin=%b rdata=%h mis=%b err=%b clr=%b want 1 0 0 0 1", o.finished, o.rdata, o.mis, o.err, o.cleared);
    end
  endtask

  task automatic test_store_byte;
    obs_t o;
    do_txn(1'b1, 1'b1, F3_B, 32'h103, 32'h0000_00AB, 32'h0, 1, 2, 1'b0, o);
    checks++;
    if ({o.addr, o.be, o.wd, o.we} !== {32'h100, 4'b1000, 32'hABAB_ABAB, 1'b1}) begin
      errors++;
      $display("FAIL sb_bus got addr=%h be=%b wd=%h we=%b want 00000100 1000 abababab 1", o.addr, o.be, o.wd, o.we);
    end
    checks++;
    if (o.stalls !== 6 || !o.finished || o.rdata !== 32'h0) begin
      errors++; $display("FAIL sb_done got stall=%0d fin=%b rdata=%h want 6 1 0", o.stalls, o.finished, o.rdata);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f3s [5] = '{F3_B, F3_BU, F3_HU, F3_H, F3_W};
    logic [31:0] as  [5] = '{32'h102, 32'h102, 32'h102, 32'h102, 32'h100};
    logic [31:0] exs [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1280, 32'h0000_1280, 32'h1280_3456};
    logic [3:0]  bes [5] = '{4'b0100, 4'b0100, 4'b1100, 4'b1100, 4'b1111};
    obs_t o;
    for (int i = 0; i < 5; i++) begin
      do_txn(1'b1, 1'b0, f3s[i], as[i], 32'h5555_5555, 32'h1280_3456, i % 2, i % 3, 1'b1, o);
      checks++;
      if ({o.finished, o.rdata, o.mis, o.err} !== {1'b1, exs[i], 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL load_%0d_rdata got fin=%b rdata=%h mis=%b err=%b want 1 %h 0 0", i, o.finished, o.rdata, o.mis, o.err, exs[i]);
      end
      checks++;
      if ({o.addr, o.be, o.we} !== {32'h100, bes[i], 1'b0}) begin
        errors++;
        $display("FAIL load_%0d_bus got addr=%h be=%b we=%b want 00000100 %b 0", i, o.addr, o.be, o.we, bes[i]);
      end
    end
  endtask

  task automatic test_misalign;
    logic        wrs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  f3s [4] = '{F3_H, F3_W, F3_BU, 3'b011};
    logic [31:0] as  [4] = '{32'h101, 32'h102, 32'h100, 32'h100};
    obs_t o;
    for (int i = 0; i < 4; i++) begin
      do_txn(!wrs[i], wrs[i], f3s[i], as[i], 32'h1234_5678, 32'h8765_4321, 0, 0, 1'b0, o);
      checks++;
      if (o.reqs !== 0 || o.stalls !== 1) begin
        errors++; $display("FAIL fault_%0d_timing got req=%0d stall=%0d want 0 1", i, o.reqs, o.stalls);
      end
      checks++;
      if ({o.finished, o.mis, o.rdata, o.err, o.cleared} !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL fault_%0d_done got fin=%b mis=%b rdata=%h err=%b clr=%b want 1 1 0 0 1", i, o.finished, o.mis, o.rdata, o.err, o.cleared);
      end
    end
  endtask

  task automatic test_timeout;
    obs_t o;
    do_txn(1'b1, 1'b0, F3_W, 32'h200, 32'h0, 32'h0, 1000, 0, 1'b0, o);
    checks++;
    if (o.reqs !== TIMEOUT || o.stalls !== TIMEOUT + 1) begin
      errors++; $display("FAIL timeout_timing got req=%0d stall=%0d want %0d %0d", o.reqs, o.stalls, TIMEOUT, TIMEOUT + 1);
    end
    checks++;
    if ({o.finished, o.err, o.rdata, o.mis, o.cleared} !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL timeout_done got fin=%b err=%b rdata=%h mis=%b clr=%b want 1 1 0 0 1", o.finished, o.err, o.rdata, o.mis, o.cleared);
    end
  endtask

  task automatic test_reset_mid;
    // Reset while REQ is asserting bus_req.
    @(negedge clk);
    rd_en = 1'b1; wr_en = 1'b0; funct3 = F3_W; addr = 32'h300;
    @(negedge clk);
    #1;
    checks++;
    if (bus_req !== 1'b1) begin
      errors++; $display("FAIL rstreq_pre got bus_req=%b want 1", bus_req);
    end
    rst = 1'b1; rd_en = 1'b0;
    #1;
    checks++;
    if (bus_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL rstreq_post got bus_req=%b stall=%b want 0 0", bus_req, stall);
    end
    #2 rst = 1'b0;
    // Reset while WAITing, then a stale response two cycles later.
    @(negedge clk);
    rd_en = 1'b1; funct3 = F3_W; addr = 32'h304;
    @(negedge clk);
    #1 bus_gnt = 1'b1;
    @(negedge clk);
    #1 bus_gnt = 1'b0;
    rst = 1'b1; rd_en = 1'b0;
    #1;
    checks++;
    if (bus_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL rstwait_post got bus_req=%b stall=%b want 0 0", bus_req, stall);
    end
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    #1 bus_rvalid = 1'b0;
    checks++;
    if ({rdata, stall, bus_req, misalign, bus_err} !== {32'h0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rstwait_stale got rdata=%h stall=%b req=%b mis=%b err=%b want 0 0 0 0 0", rdata, stall, bus_req, misalign, bus_err);
    end
  endtask

  task automatic test_random;
    obs_t        o;
    logic        rd, wr, spur, fault;
    logic [2:0]  f3;
    logic [31:0] a, wd, rw, exp_rdata;
    int          gd, rdly, exp_stalls, exp_reqs;
    for (int n = 0; n < 40; n++) begin
      rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      wd = $urandom; rw = $urandom;
      gd = $urandom_range(0, 5); rdly = $urandom_range(0, 5);
      spur = 1'($urandom_range(0, 1));
      fault      = model_fault(wr, f3, a);
      exp_reqs   = fault ? 0 : gd + 1;
      exp_stalls = fault ? 1 : gd + rdly + 3;
      exp_rdata  = (fault || wr) ? 32'h0 : model_load(f3, a, rw);
      do_txn(rd, wr, f3, a, wd, rw, gd, rdly, spur, o);
      checks++;
      if (o.reqs !== exp_reqs || o.stalls !== exp_stalls || !o.finished || !o.cleared) begin
        errors++;
        $display("FAIL rand_%0d_timing got req=%0d stall=%0d fin=%b clr=%b want %0d %0d 1 1",
                 n, o.reqs, o.stalls, o.finished, o.cleared, exp_reqs, exp_stalls);
      end
      checks++;
      if ({o.rdata, o.mis, o.err} !== {exp_rdata, fault, 1'b0}) begin
        errors++;
        $display("FAIL rand_%0d_result f3=%0d a=%h got rdata=%h mis=%b err=%b want %h %b 0", n, f3, a, o.rdata, o.mis, o.err, exp_rdata, fault);
      end
      if (!fault) begin
        checks++;
        if (o.addr !== (a & 32'hFFFF_FFFC) || o.be !== model_be(f3, a) || o.we !== wr ||
            (wr && o.wd !== model_wdata(f3, wd))) begin
          errors++;
          $display("FAIL rand_%0d_bus got addr=%h be=%b we=%b wd=%h want %h %b %b %h", n, o.addr, o.be, o.we, o.wd,
                   a & 32'hFFFF_FFFC, model_be(f3, a), wr, model_wdata(f3, wd));
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_store_word;
    test_store_byte;
    test_loads;
    test_misalign;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_bridge.md
Name: lsu_mem_bridge

Overview:
Load/store bridge directly downstream of the single-cycle datapath. It takes the datapath's data-memory request (ALU address, rs2 store data, rd_en/wr_en, funct3) and runs it as a multi-cycle req/gnt/rvalid transaction on a 32-bit word bus. It applies byte-lane steering and load sign/zero extension. While a transaction is in flight it asserts stall, which freezes the PC and suppresses register writeback.

Parameters:
TIMEOUT, 16, cycles spent in REQ+WAIT before the access is aborted with bus_err
ADDR_W, 32, address width on both sides

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
rd_en  in  1  load request from control unit
wr_en  in  1  store request from control unit
funct3  in  3  instruction[14:12], access size/sign
addr  in  ADDR_W  byte address (ALU result)
wdata  in  32  store data (rs2), right-aligned
rdata  out  32  extended load data, valid in DONE
stall  out  1  core must hold PC and suppress writeback
misalign  out  1  access fault, valid in DONE
bus_err  out  1  timeout fault, valid in DONE
bus_req  out  1  bus request, held until bus_gnt
bus_we  out  1  1 = write
bus_addr  out  ADDR_W  word-aligned address, addr[1:0] forced to 0
bus_be  out  4  byte enables
bus_wdata  out  32  lane-steered store data
bus_gnt  in  1  request accepted this cycle
bus_rvalid  in  1  response/ack (reads and writes)
bus_rdata  in  32  read word

Behaviour:
- Reset (async): state=IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, rdata=0, misalign=0, bus_err=0, timeout counter=0.
- stall = (IDLE & (rd_en|wr_en)) | REQ | WAIT. It is combinational and drops in DONE, so the core retires the instruction at the end of DONE.
- rd_en and wr_en both high: treated as a store.
- funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - Stores with BU/HU or any other encoding are illegal.
- Illegal funct3, H with addr[0]=1, or W with addr[1:0]!=0 is a fault: IDLE->DONE with misalign=1, rdata=0, and no bus activity.
- IDLE, legal request: register bus_addr, bus_we, bus_be and bus_wdata, then go to REQ.
  - bus_be: B = 1<<addr[1:0]; H = 0011 or 1100 selected by addr[1]; W = 1111.
  - bus_wdata: wdata replicated per size (byte x4, half x2, or the full word).
- REQ: bus_req=1, counter increments. bus_gnt -> WAIT.
- WAIT: bus_req=0. bus_rvalid -> capture and extend bus_rdata into rdata (0 for stores), then go to DONE.
  - rvalid arriving in the same cycle as gnt is not accepted; responses are accepted only in WAIT.
- Timeout: counter reaching TIMEOUT in REQ or WAIT -> DONE with bus_err=1, rdata=0, bus_req=0. The counter clears on leaving WAIT/REQ.
- DONE: lasts one cycle, then returns to IDLE. rdata, misalign and bus_err are held valid only in DONE and cleared on the return to IDLE.
- Load extension: select the byte/half at addr[1:0]. B/H sign-extend; BU/HU zero-extend.
- Minimum latency with a zero-wait bus (gnt in the first REQ cycle, rvalid the next cycle): stall high for 3 cycles (IDLE, REQ, WAIT), then DONE.
- Reset mid-transaction: bus_req falls immediately. rvalid/gnt arriving later is ignored in IDLE.
- Request inputs are sampled only in IDLE. The core holds them stable while stalled; changes during REQ/WAIT are ignored.

Decomposition:
- Package lsu_pkg:
  - state enum {IDLE, REQ, WAIT, DONE}
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - TIMEOUT default
- Sub-module lsu_align: combinational. Computes be, steered wdata and misalign from funct3/addr/wdata/we, and the extended load value from bus_rdata/addr/funct3. The FSM and counter stay in lsu_mem_bridge.

Test Plan:
- SW 0xDEADBEEF @0x100, gnt and rvalid with zero wait -> bus_addr=0x100, be=1111, bus_wdata=0xDEADBEEF; stall high exactly 3 cycles, then DONE.
- SB 0x000000AB @0x103 -> bus_addr=0x100, be=1000, bus_wdata=0xABABABAB, bus_we=1.
- LB @0x102 with bus_rdata=0x12803456 -> rdata=0xFFFFFF80. Same access as LBU -> 0x00000080. LHU @0x102 -> 0x00001280.
- LH @0x101 -> misalign=1 in the cycle after the request, bus_req never asserted, stall 1 cycle, rdata=0.
- LW @0x200 with bus_gnt held 0 and TIMEOUT=16 -> bus_req high for 16 cycles, then DONE with bus_err=1, rdata=0, stall released.
- rst pulsed during WAIT of an LW, rvalid arriving 2 cycles later -> bus_req=0 and stall=0 immediately, the rvalid is ignored, and rdata stays 0.
